// File: rtl/ir_adc_serial_reader_if.sv
// ADC pins plus sample/status outputs of ir_adc_serial_reader.
// master = reader side; slave = ADC pins, control source and filter side.
interface ir_adc_serial_reader_if;
   logic       enable;
   logic       clear_err;
   logic       adc_sdo;
   logic       adc_cs_n;
   logic       adc_sclk;
   logic [7:0] IR_ADC_Value;
   logic       sample_valid;
   logic       busy;
   logic       frame_err;

   modport master (
      input  enable, clear_err, adc_sdo,
      output adc_cs_n, adc_sclk, IR_ADC_Value, sample_valid, busy, frame_err
   );

   modport slave (
      output enable, clear_err, adc_sdo,
      input  adc_cs_n, adc_sclk, IR_ADC_Value, sample_valid, busy, frame_err
   );
endinterface

// File: rtl/ir_adc_serial_reader.sv
// Periodic serial ADC reader; start edge to sample_valid is CLK_DIV*(2*FRAME_BITS+2) cycles.
// No backpressure: each sample pulses sample_valid once and is held until the next one.
module ir_adc_serial_reader #(
   parameter int CLK_DIV       = 4,
   parameter int FRAME_BITS    = 16,
   parameter int LEAD_BITS     = 3,
   parameter int SAMPLE_PERIOD = 256
) (
   input  logic                   CLK_Filter,
   input  logic                   rst_n,
   ir_adc_serial_reader_if.master bus
);
   localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int N_W  = $clog2(FRAME_BITS + 1);
   localparam int PC_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

   localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
   localparam logic [N_W-1:0]  N_LAST  = N_W'(FRAME_BITS - 1);
   localparam logic [N_W-1:0]  N_DAT0  = N_W'(LEAD_BITS);
   localparam logic [N_W-1:0]  N_DAT7  = N_W'(LEAD_BITS + 7);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(SAMPLE_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

   state_t          r_state;
   logic [HC_W-1:0] r_hc;
   logic [N_W-1:0]  r_n;
   logic [PC_W-1:0] r_pcnt;
   logic [7:0]      r_shift;
   logic            r_lead_err;
   logic            r_cs_n;
   logic            r_sclk;
   logic            r_valid;
   logic            r_busy;
   logic            r_err;
   logic [7:0]      r_value;
   logic            w_hc_last;

   assign w_hc_last = (r_hc == HC_LAST);

   always_ff @(posedge CLK_Filter or negedge rst_n) begin
      if (!rst_n)
         r_pcnt <= '0;
      else if (!bus.enable || r_pcnt == PC_LAST)
         r_pcnt <= '0;
      else
         r_pcnt <= r_pcnt + 1'b1;
   end

   always_ff @(posedge CLK_Filter or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_hc       <= '0;
         r_n        <= '0;
         r_shift    <= '0;
         r_lead_err <= 1'b0;
         r_cs_n     <= 1'b1;
         r_sclk     <= 1'b1;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
         r_value    <= '0;
      end else begin
         r_valid <= 1'b0;
         // A set on the CS_HOLD exit edge below overrides this clear.
         if (bus.clear_err)
            r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.enable && r_pcnt == '0) begin
                  r_state    <= CS_SETUP;
                  r_cs_n     <= 1'b0;
                  r_busy     <= 1'b1;
                  r_hc       <= '0;
                  r_n        <= '0;
                  r_lead_err <= 1'b0;
               end
            end
            CS_SETUP: begin
               r_hc <= w_hc_last ? '0 : r_hc + 1'b1;
               if (w_hc_last)
                  r_state <= SHIFT;
            end
            SHIFT: begin
               r_hc <= w_hc_last ? '0 : r_hc + 1'b1;
               if (w_hc_last) begin
                  r_sclk <= ~r_sclk;
                  // sclk currently low: this toggle is a rising edge, so sample bit r_n.
                  if (!r_sclk) begin
                     if (r_n < N_DAT0) begin
                        if (bus.adc_sdo)
                           r_lead_err <= 1'b1;
                     end else if (r_n <= N_DAT7) begin
                        r_shift <= {r_shift[6:0], bus.adc_sdo};
                     end
                     r_n <= r_n + 1'b1;
                     if (r_n == N_LAST)
                        r_state <= CS_HOLD;
                  end
               end
            end
            CS_HOLD: begin
               r_hc <= w_hc_last ? '0 : r_hc + 1'b1;
               if (w_hc_last) begin
                  r_state <= IDLE;
                  r_cs_n  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_value <= r_shift;
                  r_valid <= 1'b1;
                  if (r_lead_err)
                     r_err <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.adc_cs_n     = r_cs_n;
   assign bus.adc_sclk     = r_sclk;
   assign bus.IR_ADC_Value = r_value;
   assign bus.sample_valid = r_valid;
   assign bus.busy         = r_busy;
   assign bus.frame_err    = r_err;
endmodule
